vcve2_vec_result_collector: RTL and testbench

Consumes the packed SIMD sums produced by the fracturable adder, one PIPE_WIDTH-bit beat per handshake. It strips the scalar LSB, assembles the beats into a VLEN-bit vector result with per-byte write enables, and presents it to vector register-file writeback. It is the result-side counterpart of the operand path: the adder writes lane results, and this block reads, packs and retires them.

---
 rtl/vcve2_pkg.sv | 34 +++
 rtl/vcve2_vec_result_collector_if.sv | 39 +++
 rtl/vcve2_beat_be_gen.sv | 26 ++
 rtl/vcve2_vec_result_collector.sv | 110 +++++++++++
 tb/tb_vcve2_vec_result_collector.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/vcve2_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vcve2_pkg
// Purpose : Shared types and helpers for the vector result collector.
//           - sew_e        : element width encoding
//           - coll_state_e : collector FSM states
//           - sew_bytes()  : element width in bytes
// Revision: 1.0  initial release
// ============================================================================
package vcve2_pkg;

  typedef enum logic [1:0] {
    SEW_8  = 2'b00,
    SEW_16 = 2'b01,
    SEW_32 = 2'b10
  } sew_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WB      = 2'd2
  } coll_state_e;

  // Encoding 2'b11 is treated as 32-bit, same as 2'b10.
  function automatic int sew_bytes(input logic [1:0] sew);
    case (sew)
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/vcve2_vec_result_collector_if.sv
`default_nettype none
// ============================================================================
// Module  : vcve2_vec_result_collector_if
// Purpose : Bundles the control, adder-result and writeback handshakes of the
//           vector result collector.
//   start_i/sew_i/vl_i/busy_o           : operation control
//   res_valid_i/res_ready_o/res_i       : adder beat handshake
//   wb_valid_o/wb_ready_i/wb_data_o/wb_be_o : writeback handshake
//   Modport slave  : collector view.
//   Modport master : driver (control + adder + writeback sink) view.
// Revision: 1.0  initial release
// ============================================================================
interface vcve2_vec_result_collector_if #(
  parameter int PIPE_WIDTH = 32,
  parameter int VLEN       = 128
);
  logic                         start_i;
  logic [1:0]                   sew_i;
  logic [$clog2(VLEN/8):0]      vl_i;
  logic                         busy_o;
  logic                         res_valid_i;
  logic                         res_ready_o;
  logic [PIPE_WIDTH+1:0]        res_i;
  logic                         wb_valid_o;
  logic                         wb_ready_i;
  logic [VLEN-1:0]              wb_data_o;
  logic [VLEN/8-1:0]            wb_be_o;

  modport slave (
    input  start_i, sew_i, vl_i, res_valid_i, res_i, wb_ready_i,
    output busy_o, res_ready_o, wb_valid_o, wb_data_o, wb_be_o
  );

  modport master (
    output start_i, sew_i, vl_i, res_valid_i, res_i, wb_ready_i,
    input  busy_o, res_ready_o, wb_valid_o, wb_data_o, wb_be_o
  );
endinterface
`default_nettype wire

// File: rtl/vcve2_beat_be_gen.sv
`default_nettype none
// ============================================================================
// Module  : vcve2_beat_be_gen
// Purpose : Byte-enable slice for one beat: byte j of beat i is enabled when
//           its absolute byte index i*(PIPE_WIDTH/8)+j is below nbytes.
//   i_beat_idx : beat index within the vector
//   i_nbytes   : number of valid bytes in the operation
//   o_be       : per-byte enables for this beat
// Revision: 1.0  initial release
// ============================================================================
module vcve2_beat_be_gen #(
  parameter int PIPE_WIDTH = 32,
  parameter int IDX_W      = 3,
  parameter int NB_W       = 5
) (
  input  wire logic [IDX_W-1:0]        i_beat_idx,
  input  wire logic [NB_W-1:0]         i_nbytes,
  output logic      [PIPE_WIDTH/8-1:0] o_be
);
  localparam int BEAT_BYTES = PIPE_WIDTH / 8;

  for (genvar j = 0; j < BEAT_BYTES; j++) begin : g_byte
    assign o_be[j] = ((int'(i_beat_idx) * BEAT_BYTES + j) < int'(i_nbytes));
  end
endmodule
`default_nettype wire

// File: rtl/vcve2_vec_result_collector.sv
`default_nettype none
// ============================================================================
// Module  : vcve2_vec_result_collector
// Purpose : Packs PIPE_WIDTH-bit adder beats into a VLEN-bit vector result
//           with byte enables and hands it to register-file writeback.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus (slave)  : control, adder beat and writeback handshakes
// Revision: 1.0  initial release
// ============================================================================
module vcve2_vec_result_collector
  import vcve2_pkg::*;
#(
  parameter int PIPE_WIDTH = 32,
  parameter int VLEN       = 128
) (
  input wire logic clk_i,
  input wire logic rst_i,
  vcve2_vec_result_collector_if.slave bus
);
  localparam int BEAT_BYTES = PIPE_WIDTH / 8;
  localparam int VBYTES     = VLEN / 8;
  localparam int NBEATS_MAX = VLEN / PIPE_WIDTH;
  localparam int CNT_W      = $clog2(NBEATS_MAX + 1);
  localparam int NB_W       = $clog2(VBYTES) + 1;

  coll_state_e             r_state;
  logic [CNT_W-1:0]        r_beat_cnt;
  logic [CNT_W-1:0]        r_nbeats;
  logic [NB_W-1:0]         r_nbytes;
  logic [VLEN-1:0]         r_data;
  logic [VBYTES-1:0]       r_be;

  int                      w_req_bytes;
  logic [NB_W-1:0]         w_nbytes;
  logic [CNT_W-1:0]        w_nbeats;
  logic [BEAT_BYTES-1:0]   w_slot_be;
  logic [PIPE_WIDTH-1:0]   w_beat_masked;
  logic                    w_unused_res;

  // Scalar LSB and top carry of the adder result carry no lane data.
  assign w_unused_res = bus.res_i[0] ^ bus.res_i[PIPE_WIDTH+1];

  // Clamping the byte count to VBYTES is the same as clamping vl to VLMAX,
  // because VBYTES is always a multiple of the element size.
  always_comb begin
    w_req_bytes = int'(bus.vl_i) * sew_bytes(bus.sew_i);
    if (w_req_bytes > VBYTES) w_req_bytes = VBYTES;
    w_nbytes = NB_W'(w_req_bytes);
    w_nbeats = CNT_W'((w_req_bytes + BEAT_BYTES - 1) / BEAT_BYTES);
  end

  vcve2_beat_be_gen #(
    .PIPE_WIDTH (PIPE_WIDTH),
    .IDX_W      (CNT_W),
    .NB_W       (NB_W)
  ) u_be_gen (
    .i_beat_idx (r_beat_cnt),
    .i_nbytes   (r_nbytes),
    .o_be       (w_slot_be)
  );

  // Bytes past nbytes are forced to zero so the tail of the last beat
  // never leaks into the written vector.
  for (genvar j = 0; j < BEAT_BYTES; j++) begin : g_mask
    assign w_beat_masked[8*j +: 8] = w_slot_be[j] ? bus.res_i[1 + 8*j +: 8] : 8'h00;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_beat_cnt <= '0;
      r_nbeats   <= '0;
      r_nbytes   <= '0;
      r_data     <= '0;
      r_be       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start_i) begin
            r_data     <= '0;
            r_be       <= '0;
            r_beat_cnt <= '0;
            r_nbytes   <= w_nbytes;
            r_nbeats   <= w_nbeats;
            r_state    <= (w_nbeats == '0) ? WB : COLLECT;
          end
        end
        COLLECT: begin
          if (bus.res_valid_i) begin
            r_data[r_beat_cnt*PIPE_WIDTH +: PIPE_WIDTH] <= w_beat_masked;
            r_be[r_beat_cnt*BEAT_BYTES +: BEAT_BYTES]   <= w_slot_be;
            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            if ((r_beat_cnt + CNT_W'(1)) == r_nbeats) r_state <= WB;
          end
        end
        WB: begin
          if (bus.wb_ready_i) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy_o      = (r_state != IDLE);
  assign bus.res_ready_o = (r_state == COLLECT);
  assign bus.wb_valid_o  = (r_state == WB);
  assign bus.wb_data_o   = r_data;
  assign bus.wb_be_o     = r_be;
endmodule
`default_nettype wire

// File: tb/tb_vcve2_vec_result_collector.sv
`default_nettype none
// ============================================================================
// Module  : tb_vcve2_vec_result_collector
// Purpose : Directed self-checking bench for vcve2_vec_result_collector.
// Revision: 1.0  initial release
// ============================================================================
module tb_vcve2_vec_result_collector;
  logic clk_i;
  logic rst_i;
  int   n_checks;
  int   n_fail;

  vcve2_vec_result_collector_if #(.PIPE_WIDTH(32), .VLEN(128)) bus ();

  vcve2_vec_result_collector #(.PIPE_WIDTH(32), .VLEN(128)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_start(input logic [1:0] sew, input logic [4:0] vl);
    bus.start_i = 1'b1;
    bus.sew_i   = sew;
    bus.vl_i    = vl;
    tick();
    bus.start_i = 1'b0;
  endtask

  // Presents one beat (value<<1, optional scalar/carry bits) until accepted.
  task automatic send_beat(input logic [31:0] val, input logic side);
    bit done;
    done = 1'b0;
    bus.res_i       = {side, val, side};
    bus.res_valid_i = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      if (bus.res_ready_o) done = 1'b1;
      tick();
    end
    bus.res_valid_i = 1'b0;
    if (!done) check("beat_timeout", 128'd0, 128'd1);
  endtask

  task automatic gap_rand();
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic finish_wb();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (bus.wb_valid_o) done = 1'b1;
      else tick();
    end
    if (!done) check("wb_timeout", 128'd0, 128'd1);
    bus.wb_ready_i = 1'b1;
    tick();
    bus.wb_ready_i = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_i           = 1'b1;
    bus.start_i     = 1'b0;
    bus.sew_i       = 2'b00;
    bus.vl_i        = '0;
    bus.res_valid_i = 1'b0;
    bus.res_i       = '0;
    bus.wb_ready_i  = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Reset state
    check("rst_busy",  128'(bus.busy_o), 128'd0);
    check("rst_ready", 128'(bus.res_ready_o), 128'd0);
    check("rst_wbv",   128'(bus.wb_valid_o), 128'd0);
    check("rst_data",  bus.wb_data_o, 128'd0);
    check("rst_be",    128'(bus.wb_be_o), 128'd0);

    // sew=32, vl=4: four full beats
    do_start(2'b10, 5'd4);
    check("t1_ready", 128'(bus.res_ready_o), 128'd1);
    check("t1_busy",  128'(bus.busy_o), 128'd1);
    send_beat(32'h11111111, 1'b0);
    send_beat(32'h22222222, 1'b0);
    send_beat(32'h33333333, 1'b0);
    check("t1_wbv_early", 128'(bus.wb_valid_o), 128'd0);
    send_beat(32'h44444444, 1'b0);
    check("t1_wbv",  128'(bus.wb_valid_o), 128'd1);
    check("t1_data", bus.wb_data_o, 128'h44444444_33333333_22222222_11111111);
    check("t1_be",   128'(bus.wb_be_o), 128'hFFFF);
    finish_wb();
    check("t1_idle", 128'(bus.busy_o), 128'd0);
    tick();

    // sew=8, vl=6: tail bytes of beat 1 must be dropped
    do_start(2'b00, 5'd6);
    send_beat(32'hA1A2A3A4, 1'b0);
    send_beat(32'hFFFFB5B6, 1'b0);
    check("t2_wbv",  128'(bus.wb_valid_o), 128'd1);
    check("t2_data", bus.wb_data_o, 128'h0000B5B6_A1A2A3A4);
    check("t2_be",   128'(bus.wb_be_o), 128'h003F);
    finish_wb();
    tick();

    // sew=16, vl=20 clamps to 8 elements = 4 beats; 5th beat not taken
    do_start(2'b01, 5'd20);
    send_beat(32'h00010002, 1'b0);
    send_beat(32'h00030004, 1'b0);
    send_beat(32'h00050006, 1'b0);
    send_beat(32'h00070008, 1'b0);
    check("t3_wbv", 128'(bus.wb_valid_o), 128'd1);
    bus.res_i       = {1'b0, 32'hDEADBEEF, 1'b0};
    bus.res_valid_i = 1'b1;
    tick();
    tick();
    check("t3_ready5", 128'(bus.res_ready_o), 128'd0);
    check("t3_data", bus.wb_data_o, 128'h00070008_00050006_00030004_00010002);
    check("t3_be",   128'(bus.wb_be_o), 128'hFFFF);
    bus.res_valid_i = 1'b0;
    finish_wb();
    tick();

    // vl=0: straight to WB with empty enables, held while wb_ready low
    do_start(2'b10, 5'd0);
    check("t4_wbv",   128'(bus.wb_valid_o), 128'd1);
    check("t4_ready", 128'(bus.res_ready_o), 128'd0);
    check("t4_be",    128'(bus.wb_be_o), 128'd0);
    repeat (3) tick();
    check("t4_wbv_hold", 128'(bus.wb_valid_o), 128'd1);
    check("t4_data", bus.wb_data_o, 128'd0);
    finish_wb();
    check("t4_idle", 128'(bus.busy_o), 128'd0);
    tick();

    // Reset mid-operation, then a single-element op with side bits set
    do_start(2'b10, 5'd4);
    send_beat(32'h55555555, 1'b0);
    send_beat(32'h66666666, 1'b0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("t5_busy", 128'(bus.busy_o), 128'd0);
    check("t5_ready", 128'(bus.res_ready_o), 128'd0);
    check("t5_wbv",  128'(bus.wb_valid_o), 128'd0);
    check("t5_data", bus.wb_data_o, 128'd0);
    check("t5_be",   128'(bus.wb_be_o), 128'd0);
    do_start(2'b10, 5'd1);
    send_beat(32'hCAFEBABE, 1'b1);
    check("t5b_wbv",  128'(bus.wb_valid_o), 128'd1);
    check("t5b_data", bus.wb_data_o, 128'h00000000_00000000_00000000_CAFEBABE);
    check("t5b_be",   128'(bus.wb_be_o), 128'h000F);
    finish_wb();
    tick();

    // Random gaps in res_valid, stray starts during COLLECT and WB
    do_start(2'b01, 5'd8);
    gap_rand();
    send_beat(32'h01234567, 1'b0);
    gap_rand();
    bus.start_i = 1'b1;
    bus.sew_i   = 2'b00;
    bus.vl_i    = 5'd1;
    send_beat(32'h89ABCDEF, 1'b0);
    bus.start_i = 1'b0;
    gap_rand();
    send_beat(32'h0F1E2D3C, 1'b0);
    gap_rand();
    send_beat(32'h4B5A6978, 1'b0);
    bus.start_i = 1'b1;
    tick();
    tick();
    bus.start_i = 1'b0;
    check("t6_wbv",  128'(bus.wb_valid_o), 128'd1);
    check("t6_data", bus.wb_data_o, 128'h4B5A6978_0F1E2D3C_89ABCDEF_01234567);
    check("t6_be",   128'(bus.wb_be_o), 128'hFFFF);
    finish_wb();
    check("t6_idle", 128'(bus.busy_o), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
